aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Sequencer for the iterative AES-128 encryption core. It reuses one shared round datapath (subBytes → ShiftRows → Mix_columns → AddRoundKey) for NROUNDS rounds. It owns the round counter, the key-schedule handshake, the state-register load/enable strobes and the final-round MixColumns bypass. It sits between the top-level request interface and the round datapath and key expansion unit, and holds no data itself.

## Interface
- WIDTH, 8, byte width, shared with the datapath.
- DIM, 4, state matrix dimension, shared with the datapath.
- NROUNDS, 10, number of full rounds; round 0 is the initial AddRoundKey.
- TIMEOUT, 16, maximum cycles waiting for key_ack_i before aborting with error.
- clk_i  in  1  single clock; all state changes on its rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  encryption request; accepted only when ready_o=1.
- abort_i  in  1  synchronous abort; returns the block to IDLE.
- key_ack_i  in  1  round key for rnd_o is valid this cycle.
- ready_o  out  1  block is in IDLE and accepts start_i.
- busy_o  out  1  inverse of ready_o.
- key_req_o  out  1  requests the round key for rnd_o.
- rnd_o  out  $clog2(NROUNDS+1)  current round index, 0..NROUNDS.
- ld_state_o  out  1  load state register with plaintext XOR key0.
- st_en_o  out  1  capture datapath output into state register.
- bypass_mix_o  out  1  route ShiftRows output around Mix_columns.
- done_o  out  1  one-cycle pulse: ciphertext valid in state register.
- err_o  out  1  one-cycle pulse: key timeout abort.

## Operation
- States: IDLE, KEY0, KEYW, EXEC, DONE, ERR. All outputs are Moore (decoded from state and round counter).
- IDLE:
  - ready_o=1.
  - start_i=1 → KEY0 with rnd=0.
- KEY0:
  - key_req_o=1, rnd_o=0.
  - On key_ack_i: ld_state_o=1, rnd←1, → KEYW.
- KEYW:
  - key_req_o=1, rnd_o=r.
  - On key_ack_i → EXEC.
- EXEC:
  - st_en_o=1; bypass_mix_o=1 only when r==NROUNDS.
  - If r==NROUNDS → DONE; otherwise rnd←r+1 → KEYW.
- DONE:
  - done_o=1 → IDLE.
- ERR:
  - err_o=1 → IDLE.
- ld_state_o is combinational in KEY0: it equals key_ack_i. This is the only Mealy output.
- Watchdog counter:
  - Counts consecutive cycles in KEY0/KEYW with key_ack_i=0; clears on ack or on leaving those states.
  - Reaching TIMEOUT → ERR.
  - Width is $clog2(TIMEOUT+1); it saturates and never wraps.
- Round counter never exceeds NROUNDS. Increment happens only in EXEC with r<NROUNDS.
- Priority when events coincide:
  - abort_i beats key_ack_i and timeout: → IDLE, and no ld_state_o, st_en_o, done_o or err_o that cycle.
  - key_ack_i beats timeout in the same cycle.
- Ignored inputs:
  - start_i outside IDLE.
  - key_ack_i when key_req_o=0.
  - abort_i in IDLE.
  - abort_i in DONE or ERR (the pulse completes).

## Timing
- Reset values: state IDLE, rnd 0, watchdog 0, ready_o=1, busy_o=0. All strobes (key_req_o, ld_state_o, st_en_o, bypass_mix_o, done_o, err_o) are 0.
- Reset mid-operation: outputs take their reset values immediately (asynchronously), with no done_o or err_o.
- Latency with zero-wait ack, start accepted at cycle T:
  - KEY0 at T+1, where ld_state_o=1.
  - Round k: KEYW at T+2k, EXEC at T+2k+1.
  - Last EXEC at T+2·NROUNDS+1 = T+21.
  - done_o at T+22.
  - ready_o=1 at T+23.
- Each key wait cycle adds exactly one cycle to the total.
- Back-to-back operation: start_i held high is accepted at T+23, giving a 23-cycle minimum period.

## Structure
- Shared package aes_pkg holds:
  - WIDTH, DIM and NROUNDS constants.
  - matrix_t typedef (shared with the datapath).
  - State enum ctrl_state_t, encoded as 3-bit logic.
- Single module. The round counter and watchdog are inline counters, with no sub-module.
- The datapath is instantiated alongside this block by the parent, not inside it.

## Test plan
- Zero-wait run: reset, start_i pulse at T with key_ack_i tied high → ld_state_o at T+1 only; st_en_o at T+3,5,…,21 (10 pulses); bypass_mix_o only at T+21; done_o only at T+22; rnd_o steps 0..10.
- Key stalls: key_ack_i low for 3 cycles in round 4 KEYW, otherwise high → done_o at T+25, and rnd_o holds 4 during the stall.
- Timeout: key_ack_i held low after start → err_o pulse after TIMEOUT=16 wait cycles in KEY0; no ld_state_o or done_o; ready_o=1 on the next cycle.
- Abort collision: abort_i and key_ack_i both high in round 7 KEYW → IDLE next cycle, no st_en_o, no done_o; a fresh start then completes normally with rnd_o restarting at 0.
- Ignored inputs: start_i pulsed during round 3, and key_ack_i pulsed during EXEC → no effect on the sequence; done_o still at T+22.
- Async reset asserted in EXEC round 5, mid-cycle → all strobes drop to 0 without waiting for a clock edge, rnd_o=0, ready_o=1; no done_o after release.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: constants, state matrix type and controller state encoding shared by the AES-128 core.
package aes_pkg;
  localparam int WIDTH = 8;
  localparam int DIM = 4;
  localparam int NROUNDS = 10;
  localparam int RND_W = $clog2(NROUNDS + 1);
  typedef logic [DIM-1:0][DIM-1:0][WIDTH-1:0] matrix_t;
  typedef enum logic [2:0] {IDLE, KEY0, KEYW, EXEC, DONE, ERR} ctrl_state_t;
endpackage

// File: rtl/aes_round_ctrl_if.sv
// aes_round_ctrl_if: request, key-schedule handshake and datapath strobes of the round sequencer.
// master drives start_i/abort_i/key_ack_i; slave (the sequencer) drives the status and strobe outputs.
interface aes_round_ctrl_if;
  logic start_i;
  logic abort_i;
  logic key_ack_i;
  logic ready_o;
  logic busy_o;
  logic key_req_o;
  logic [aes_pkg::RND_W-1:0] rnd_o;
  logic ld_state_o;
  logic st_en_o;
  logic bypass_mix_o;
  logic done_o;
  logic err_o;
  modport master (
    output start_i, abort_i, key_ack_i,
    input ready_o, busy_o, key_req_o, rnd_o, ld_state_o, st_en_o, bypass_mix_o, done_o, err_o
  );
  modport slave (
    input start_i, abort_i, key_ack_i,
    output ready_o, busy_o, key_req_o, rnd_o, ld_state_o, st_en_o, bypass_mix_o, done_o, err_o
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences the shared AES-128 round datapath over NROUNDS rounds with key handshake and timeout.
// clk_i: clock; rst_i: async active-low reset; bus: request/key handshake inputs, state strobes and status outputs.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input logic clk_i,
  input logic rst_i,
  aes_round_ctrl_if.slave bus
);
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [RND_W-1:0] RMAX = RND_W'(NROUNDS);
  localparam logic [WD_W-1:0] WLAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WSAT = WD_W'(TIMEOUT);
  ctrl_state_t state, state_n;
  logic [RND_W-1:0] rnd, rnd_n;
  logic [WD_W-1:0] wd, wd_n;
  logic in_key, waiting, tmo;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      rnd <= '0;
      wd <= '0;
    end else begin
      state <= state_n;
      rnd <= rnd_n;
      wd <= wd_n;
    end
  end
  assign in_key = state == KEY0 || state == KEYW;
  assign waiting = in_key && !bus.key_ack_i;
  // this wait cycle is the TIMEOUT-th consecutive one
  assign tmo = waiting && wd == WLAST;
  always_comb begin
    state_n = state;
    rnd_n = rnd;
    wd_n = waiting ? (wd == WSAT ? wd : wd + 1'b1) : '0;
    case (state)
      IDLE: state_n = bus.start_i ? KEY0 : IDLE;
      KEY0: begin
        state_n = bus.abort_i ? IDLE : bus.key_ack_i ? KEYW : tmo ? ERR : KEY0;
        rnd_n = (!bus.abort_i && bus.key_ack_i) ? RND_W'(1) : rnd;
      end
      KEYW: state_n = bus.abort_i ? IDLE : bus.key_ack_i ? EXEC : tmo ? ERR : KEYW;
      EXEC: begin
        state_n = bus.abort_i ? IDLE : rnd == RMAX ? DONE : KEYW;
        rnd_n = (!bus.abort_i && rnd != RMAX) ? rnd + 1'b1 : rnd;
      end
      default: state_n = IDLE;
    endcase
    if (state_n == IDLE) rnd_n = '0;
    if (state_n != KEY0 && state_n != KEYW) wd_n = '0;
  end
  assign bus.ready_o = state == IDLE;
  assign bus.busy_o = state != IDLE;
  assign bus.key_req_o = in_key;
  assign bus.rnd_o = rnd;
  // Mealy: the plaintext load coincides with the key0 acknowledge
  assign bus.ld_state_o = state == KEY0 && bus.key_ack_i && !bus.abort_i;
  assign bus.st_en_o = state == EXEC;
  assign bus.bypass_mix_o = state == EXEC && rnd == RMAX;
  assign bus.done_o = state == DONE;
  assign bus.err_o = state == ERR;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: scoreboard bench for the AES round sequencer timing, stalls, timeout, abort and async reset.
module tb_aes_round_ctrl;
  typedef struct packed {
    logic ready, busy, key_req, ld, st_en, byp, done, err;
    logic chk_rnd;
    logic [3:0] rnd;
  } exp_t;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  string cur = "";
  int cur_o = 0;
  exp_t q[$];
  aes_round_ctrl_if bus();
  aes_round_ctrl #(.TIMEOUT(16)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic exp_t e_idle();
    exp_t e = '0;
    e.ready = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_key(input int r, input logic ld);
    exp_t e = '0;
    e.busy = 1'b1;
    e.key_req = 1'b1;
    e.ld = ld;
    e.chk_rnd = 1'b1;
    e.rnd = 4'(r);
    return e;
  endfunction
  // expected outputs at offset o after the accepting cycle, with an n-cycle key stall in round s
  function automatic exp_t run_exp(input int o, input int s, input int n);
    exp_t e = '0;
    int p;
    if (o == 1) return e_key(0, 1'b1);
    if (n > 0 && o >= 2 * s && o <= 2 * s + n) return e_key(s, 1'b0);
    p = (o > 2 * s + n) ? o - n : o;
    if (p <= 21 && p % 2 == 0) return e_key(p / 2, 1'b0);
    if (p <= 21) begin
      e.busy = 1'b1;
      e.st_en = 1'b1;
      e.byp = p == 21;
      e.chk_rnd = 1'b1;
      e.rnd = 4'((p - 1) / 2);
    end else if (p == 22) begin
      e.busy = 1'b1;
      e.done = 1'b1;
    end else e = e_idle();
    return e;
  endfunction
  task automatic cmp_out();
    exp_t e = q.pop_front();
    chk($sformatf("%s o=%0d strobes", cur, cur_o),
        {bus.ready_o, bus.busy_o, bus.key_req_o, bus.ld_state_o, bus.st_en_o, bus.bypass_mix_o, bus.done_o, bus.err_o},
        {e.ready, e.busy, e.key_req, e.ld, e.st_en, e.byp, e.done, e.err});
    if (e.chk_rnd) chk($sformatf("%s o=%0d rnd", cur, cur_o), bus.rnd_o, e.rnd);
  endtask
  task automatic step(input logic st, input logic ab, input logic ak, input exp_t e);
    @(negedge clk_i);
    bus.start_i = st;
    bus.abort_i = ab;
    bus.key_ack_i = ak;
    q.push_back(e);
    #1;
    cmp_out();
  endtask
  task automatic do_run(input string name, input int s, input int n, input int st_o, input int ab_o, input int max_o);
    cur = name;
    cur_o = 0;
    step(1'b1, 1'b0, 1'b1, e_idle());
    for (int o = 1; o <= max_o; o++) begin
      cur_o = o;
      step(o == st_o, o == ab_o, !(n > 0 && o >= 2 * s && o < 2 * s + n),
           (ab_o > 0 && o > ab_o) ? e_idle() : run_exp(o, s, n));
    end
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    bus.key_ack_i = 1'b0;
    cur = "reset";
    #2;
    q.push_back(e_key(0, 1'b0));
    q[0] = e_idle();
    q[0].chk_rnd = 1'b1;
    cmp_out();
    @(negedge clk_i);
    rst_i = 1'b1;
    do_run("zero_wait", 0, 0, -1, -1, 23);
    do_run("stall", 4, 3, -1, -1, 26);
    do_run("ignored", 0, 0, 6, -1, 23);
    cur = "timeout";
    cur_o = 0;
    step(1'b1, 1'b0, 1'b0, e_idle());
    for (int o = 1; o <= 16; o++) begin
      cur_o = o;
      step(1'b0, 1'b0, 1'b0, e_key(0, 1'b0));
    end
    cur_o = 17;
    q.push_back('0);
    q[$].busy = 1'b1;
    q[$].err = 1'b1;
    @(negedge clk_i);
    #1;
    cmp_out();
    cur_o = 18;
    step(1'b0, 1'b0, 1'b0, e_idle());
    do_run("abort", 0, 0, -1, 14, 16);
    do_run("after_abort", 0, 0, -1, -1, 23);
    do_run("async_rst", 0, 0, -1, -1, 11);
    #1;
    rst_i = 1'b0;
    #1;
    cur_o = 99;
    q.push_back(e_idle());
    q[$].chk_rnd = 1'b1;
    cmp_out();
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int o = 1; o <= 24; o++) begin
      cur_o = 100 + o;
      step(1'b0, 1'b0, 1'b1, e_idle());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
